// File: rtl/scariv_fpu_divsqrt_sched.sv
// Shares one iterative FP div/sqrt unit between REQ_NUM FPU pipes.
// Round-robin grant, single outstanding op, kill/flush drops the response.
module scariv_fpu_divsqrt_sched #(
   parameter int unsigned REQ_NUM = 2,
   parameter int unsigned OP_W    = 200,
   parameter int unsigned RES_W   = 69,
   parameter int unsigned TAG_W   = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [REQ_NUM-1:0]         i_req_valid,
   input  logic [REQ_NUM*OP_W-1:0]    i_req_op,
   input  logic [REQ_NUM*TAG_W-1:0]   i_req_tag,
   output logic [REQ_NUM-1:0]         o_req_grant,
   output logic [REQ_NUM-1:0]         o_req_block,
   output logic                       o_busy,
   output logic                       o_ds_valid,
   output logic [OP_W-1:0]            o_ds_op,
   input  logic                       i_ds_ready,
   input  logic                       i_ds_done,
   input  logic [RES_W-1:0]           i_ds_result,
   output logic [REQ_NUM-1:0]         o_rsp_valid,
   output logic [RES_W-1:0]           o_rsp_result,
   output logic [TAG_W-1:0]           o_rsp_tag,
   input  logic [REQ_NUM-1:0]         i_kill,
   input  logic                       i_flush
);

   localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic               r_killed;
   logic [OP_W-1:0]    r_ds_op;
   logic [TAG_W-1:0]   r_tag;
   logic [RES_W-1:0]   r_rsp_result;
   logic [REQ_NUM-1:0] r_rsp_valid;

   logic [OP_W-1:0]    w_op_arr  [REQ_NUM];
   logic [TAG_W-1:0]   w_tag_arr [REQ_NUM];
   logic [REQ_NUM-1:0] w_grant;
   logic [PTR_W-1:0]   w_grant_idx;
   logic               w_grant_any;
   logic               w_kill_now;

   for (genvar g = 0; g < REQ_NUM; g++) begin : g_slice
      assign w_op_arr[g]  = i_req_op[g*OP_W +: OP_W];
      assign w_tag_arr[g] = i_req_tag[g*TAG_W +: TAG_W];
   end

   // First valid requester at or after rr_ptr, wrapping; flush suppresses the grant.
   always_comb begin : p_grant
      int unsigned cand;
      cand        = 0;
      w_grant     = '0;
      w_grant_idx = '0;
      w_grant_any = 1'b0;
      if (r_state == ST_IDLE && !i_flush) begin
         for (int unsigned k = 0; k < REQ_NUM; k++) begin
            cand = (32'(r_rr_ptr) + k) % REQ_NUM;
            if (!w_grant_any && i_req_valid[PTR_W'(cand)]) begin
               w_grant[PTR_W'(cand)] = 1'b1;
               w_grant_idx           = PTR_W'(cand);
               w_grant_any           = 1'b1;
            end
         end
      end
   end

   assign w_kill_now = i_flush | i_kill[r_owner];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_killed     <= 1'b0;
         r_ds_op      <= '0;
         r_tag        <= '0;
         r_rsp_result <= '0;
         r_rsp_valid  <= '0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_any) begin
                  r_ds_op  <= w_op_arr[w_grant_idx];
                  r_tag    <= w_tag_arr[w_grant_idx];
                  r_owner  <= w_grant_idx;
                  r_killed <= 1'b0;
                  r_rr_ptr <= PTR_W'((32'(w_grant_idx) + 32'd1) % REQ_NUM);
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_kill_now) r_killed <= 1'b1;
               if (i_ds_ready) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_kill_now) r_killed <= 1'b1;
               if (i_ds_done) begin
                  r_rsp_result <= i_ds_result;
                  // A kill arriving with done still suppresses the response.
                  if (!r_killed && !w_kill_now) r_rsp_valid <= REQ_NUM'(1) << r_owner;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert (!(i_ds_done && r_state != ST_WAIT))
            else $error("i_ds_done asserted while no operation is waiting");
      end
   end

   assign o_req_grant  = w_grant;
   assign o_req_block  = i_req_valid & ~w_grant;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_ds_valid   = (r_state == ST_ISSUE);
   assign o_ds_op      = r_ds_op;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_tag    = r_tag;

endmodule
